// File: rtl/fifo_sync_flags_if.sv
// fifo_sync_flags_if
//   Bundles the write/read handshake, status flags and error controls of
//   fifo_sync_flags. Clock and reset are kept as plain module ports.
//
//   Signals (master = producer/consumer side, slave = FIFO side):
//     winc, wdata          write request and data        (master -> slave)
//     rinc                 read request / FWFT pop       (master -> slave)
//     clr_err              clear sticky error flags      (master -> slave)
//     wfull, walmost_full  write-side status             (slave -> master)
//     rdata                read data                     (slave -> master)
//     rempty, ralmost_empty read-side status             (slave -> master)
//     count                occupancy 0..DEPTH            (slave -> master)
//     overflow, underflow  sticky error flags            (slave -> master)
interface fifo_sync_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wfull;
  logic                  walmost_full;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rempty;
  logic                  ralmost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  modport master (
    output winc, wdata, rinc, clr_err,
    input  wfull, walmost_full, rdata, rempty, ralmost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc, clr_err,
    output wfull, walmost_full, rdata, rempty, ralmost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags
//   Single-clock FIFO with occupancy count, programmable almost-full /
//   almost-empty flags, sticky overflow / underflow flags and a selectable
//   first-word-fall-through read mode.
//
//   Ports:
//     wclk    in  : clock for every register in the block
//     wrst_n  in  : asynchronous active-low reset (release is synchronous
//                   to wclk by construction of the driving logic)
//     ff      if  : fifo_sync_flags_if.slave handshake/status bundle
//
//   Parameters:
//     DATA_WIDTH, ADDR_WIDTH (DEPTH = 2**ADDR_WIDTH),
//     AFULL_THRESH  (walmost_full  when count >= AFULL_THRESH),
//     AEMPTY_THRESH (ralmost_empty when count <= AEMPTY_THRESH),
//     FWFT          (0 = registered read, 1 = first-word-fall-through).
//   Legal: 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH.
module fifo_sync_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic             wclk,
  input  logic             wrst_n,
  fifo_sync_flags_if.slave ff
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C   = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C  = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] ZERO_C    = '0;

  // Flag decode helpers, all evaluated on the next occupancy value so the
  // registered flags move on the same edge as count.
  function automatic logic is_full(input logic [ADDR_WIDTH:0] c);
    return c == DEPTH_C;
  endfunction

  function automatic logic is_empty(input logic [ADDR_WIDTH:0] c);
    return c == ZERO_C;
  endfunction

  function automatic logic is_almost_full(input logic [ADDR_WIDTH:0] c);
    return c >= AFULL_C;
  endfunction

  function automatic logic is_almost_empty(input logic [ADDR_WIDTH:0] c);
    return c <= AEMPTY_C;
  endfunction

  // Sticky error update: a set wins over a clear in the same cycle.
  function automatic logic sticky_next(input logic cur, input logic set,
                                       input logic clr);
    if (set) return 1'b1;
    if (clr) return 1'b0;
    return cur;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wptr_p0;
  logic [ADDR_WIDTH:0] rptr_p0;
  logic [ADDR_WIDTH:0] count_p0;
  logic                full_p0;
  logic                empty_p0;
  logic                afull_p0;
  logic                aempty_p0;
  logic                ovf_p0;
  logic                unf_p0;

  logic                wr_acc;
  logic                rd_acc;
  logic [ADDR_WIDTH:0] wptr_nxt;
  logic [ADDR_WIDTH:0] rptr_nxt;
  logic [ADDR_WIDTH:0] count_nxt;

  // Stage p0: request acceptance and next-state arithmetic
  always_comb begin
    wr_acc    = ff.winc && !full_p0;
    rd_acc    = ff.rinc && !empty_p0;
    wptr_nxt  = wptr_p0 + {{ADDR_WIDTH{1'b0}}, wr_acc};
    rptr_nxt  = rptr_p0 + {{ADDR_WIDTH{1'b0}}, rd_acc};
    // Pointers carry one extra wrap bit, so their modular difference is the
    // exact occupancy 0..DEPTH and stays consistent with the pointers.
    count_nxt = wptr_nxt - rptr_nxt;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_p0   <= '0;
      rptr_p0   <= '0;
      count_p0  <= '0;
      full_p0   <= 1'b0;
      empty_p0  <= 1'b1;
      afull_p0  <= 1'b0;
      aempty_p0 <= 1'b1;
      ovf_p0    <= 1'b0;
      unf_p0    <= 1'b0;
    end else begin
      wptr_p0   <= wptr_nxt;
      rptr_p0   <= rptr_nxt;
      count_p0  <= count_nxt;
      full_p0   <= is_full(count_nxt);
      empty_p0  <= is_empty(count_nxt);
      afull_p0  <= is_almost_full(count_nxt);
      aempty_p0 <= is_almost_empty(count_nxt);
      ovf_p0    <= sticky_next(ovf_p0, ff.winc && full_p0, ff.clr_err);
      unf_p0    <= sticky_next(unf_p0, ff.rinc && empty_p0, ff.clr_err);
    end
  end

  // Storage is data only: no reset, written solely on accepted writes.
  always_ff @(posedge wclk) begin
    if (wrst_n && wr_acc) begin
      mem[wptr_p0[ADDR_WIDTH-1:0]] <= ff.wdata;
    end
  end

  // Stage p1: read data presentation
  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_WIDTH-1:0] rdata_p1;

      // rdata is architecturally visible with a defined reset value, so it
      // is reset even though it is a data register.
      always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
          rdata_p1 <= '0;
        end else if (rd_acc) begin
          rdata_p1 <= mem[rptr_p0[ADDR_WIDTH-1:0]];
        end
      end

      assign ff.rdata = rdata_p1;
    end else begin : g_fwft_read
      // Head entry is shown directly; valid whenever rempty is low.
      assign ff.rdata = mem[rptr_p0[ADDR_WIDTH-1:0]];
    end
  endgenerate

  assign ff.count         = count_p0;
  assign ff.wfull         = full_p0;
  assign ff.rempty        = empty_p0;
  assign ff.walmost_full  = afull_p0;
  assign ff.ralmost_empty = aempty_p0;
  assign ff.overflow      = ovf_p0;
  assign ff.underflow     = unf_p0;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags
//   Drives a registered-read instance and an FWFT instance of fifo_sync_flags
//   with identical stimulus. A queue-based reference model tracks contents
//   and sticky errors; read words expected from the registered instance are
//   queued and popped by a separate monitor when the DUT accepts a read.
module tb_fifo_sync_flags;

  logic wclk;
  logic wrst_n;

  fifo_sync_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if0 ();
  fifo_sync_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if1 ();

  fifo_sync_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(14),
                    .AEMPTY_THRESH(2), .FWFT(0))
    u_reg (.wclk(wclk), .wrst_n(wrst_n), .ff(if0));

  fifo_sync_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(14),
                    .AEMPTY_THRESH(2), .FWFT(1))
    u_fwft (.wclk(wclk), .wrst_n(wrst_n), .ff(if1));

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model
  logic [7:0] mq[$];
  logic       m_ovf;
  logic       m_unf;
  logic [7:0] exp0[$];
  logic [7:0] last0;
  logic       acc0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [10:0] model_vec();
    int n;
    n = mq.size();
    return {5'(n), n == 16, n >= 14, n == 0, n <= 2, m_ovf, m_unf};
  endfunction

  function automatic logic [10:0] dut_vec0();
    return {if0.count, if0.wfull, if0.walmost_full, if0.rempty,
            if0.ralmost_empty, if0.overflow, if0.underflow};
  endfunction

  function automatic logic [10:0] dut_vec1();
    return {if1.count, if1.wfull, if1.walmost_full, if1.rempty,
            if1.ralmost_empty, if1.overflow, if1.underflow};
  endfunction

  task automatic model_clear();
    mq.delete();
    exp0.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    last0 = 8'h00;
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r,
                       input logic c);
    if0.winc = w; if0.wdata = d; if0.rinc = r; if0.clr_err = c;
    if1.winc = w; if1.wdata = d; if1.rinc = r; if1.clr_err = c;
  endtask

  // One clock of stimulus, model update at the edge, flag check after it.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic c);
    logic full, empty, wa, ra;
    logic [7:0] tmp;
    @(negedge wclk);
    drive(w, d, r, c);
    @(posedge wclk);
    full  = (mq.size() == 16);
    empty = (mq.size() == 0);
    wa    = w && !full;
    ra    = r && !empty;
    if (ra) begin
      tmp = mq.pop_front();
      exp0.push_back(tmp);
    end
    if (wa) mq.push_back(d);
    if (w && full) m_ovf = 1'b1;
    else if (c)    m_ovf = 1'b0;
    if (r && empty) m_unf = 1'b1;
    else if (c)     m_unf = 1'b0;
    #2;
    chk("flags_reg", 32'(dut_vec0()), 32'(model_vec()));
    chk("flags_fwft", 32'(dut_vec1()), 32'(model_vec()));
    if (mq.size() > 0) chk("fwft_head", 32'(if1.rdata), 32'(mq[0]));
  endtask

  // Monitor: notes read acceptance at the edge, then pops the scoreboard
  // on the following falling edge and compares rdata (which must hold
  // between accepted reads).
  always @(posedge wclk) acc0 <= wrst_n && if0.rinc && !if0.rempty;

  always @(negedge wclk) begin
    if (wrst_n) begin
      if (acc0) begin
        if (exp0.size() == 0) chk("rd_sb_empty", 32'd1, 32'd0);
        else last0 = exp0.pop_front();
      end
      chk("rdata_reg", 32'(if0.rdata), 32'(last0));
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int pw;
    wrst_n = 1'b0;
    acc0   = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    model_clear();

    // Reset held for three cycles
    repeat (3) @(posedge wclk);
    #2;
    chk("rst_flags_reg", 32'(dut_vec0()), 32'(model_vec()));
    chk("rst_flags_fwft", 32'(dut_vec1()), 32'(model_vec()));
    chk("rst_rdata", 32'(if0.rdata), 32'h0);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Fill, overflow, clear
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set", 32'(if0.overflow), 32'd1);
    chk("count_full", 32'(if0.count), 32'd16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(if0.overflow), 32'd0);

    // Drain, underflow, rdata holds last word
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_set", 32'(if0.underflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rdata_hold", 32'(if0.rdata), 32'h0F);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // FWFT single word
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("fwft_5a", 32'(if1.rdata), 32'h5A);
    chk("fwft_nempty", 32'(if1.rempty), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_pop_empty", 32'(if1.rempty), 32'd1);

    // Half full, then sustained simultaneous traffic across pointer wrap
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
    chk("simul_count", 32'(if0.count), 32'd8);

    // Simultaneous op at full
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("full_simul_count", 32'(if0.count), 32'd15);
    chk("full_simul_ovf", 32'(if0.overflow), 32'd1);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b1);

    // Randomized traffic, alternating write-heavy and read-heavy phases
    for (int seg = 0; seg < 6; seg++) begin
      pw = (seg % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 50; i++)
        step($urandom_range(0, 99) < pw, 8'($urandom),
             $urandom_range(0, 99) < (100 - pw),
             $urandom_range(0, 15) == 0);
    end

    // Reset pulse between edges in the middle of operation
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    wrst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(if0.count), 32'd0);
    chk("midrst_rempty", 32'(if0.rempty), 32'd1);
    chk("midrst_count_fwft", 32'(if1.count), 32'd0);
    model_clear();
    #1;
    wrst_n = 1'b1;
    step(1'b1, 8'h33, 1'b0, 1'b0);
    chk("post_rst_fwft", 32'(if1.rdata), 32'h33);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_rdata", 32'(if0.rdata), 32'h33);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
# fifo_sync_flags

Parametrised single-clock FIFO. It succeeds the team's dual-clock FIFO for paths where producer and consumer share one clock, and keeps the same `winc`/`wfull`/`rinc`/`rempty` handshake. On top of that handshake it adds:
- an occupancy count;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags;
- a selectable first-word-fall-through (FWFT) read mode.

## Interface
Parameters:
- `DATA_WIDTH`, 8, word width.
- `ADDR_WIDTH`, 4, address width; DEPTH = 2**ADDR_WIDTH (16 by default).
- `AFULL_THRESH`, 14, `walmost_full` asserts when count >= this value.
- `AEMPTY_THRESH`, 2, `ralmost_empty` asserts when count <= this value.
- `FWFT`, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- Legal range: 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH.

Ports:
- `wclk` in 1: the single clock for the whole block; every register is on its rising edge.
- `wrst_n` in 1: reset, asynchronous assert, active-low.
- `winc` in 1: write request.
- `wdata` in DATA_WIDTH: write data.
- `wfull` out 1: FIFO full.
- `walmost_full` out 1: count >= AFULL_THRESH.
- `rinc` in 1: read request.
- `rdata` out DATA_WIDTH: read data.
- `rempty` out 1: FIFO empty.
- `ralmost_empty` out 1: count <= AEMPTY_THRESH.
- `count` out ADDR_WIDTH+1: occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a write was attempted while full.
- `underflow` out 1: sticky; a read was attempted while empty.
- `clr_err` in 1: synchronous clear of `overflow` and `underflow`.

## Operation
- **Write acceptance:** a write is accepted when `winc && !wfull`. The word goes to `mem[wptr]` and `wptr` increments.
- **Read acceptance:** a read is accepted when `rinc && !rempty`. `rptr` increments.
- **Rejected requests:**
  - A rejected write leaves memory and `wptr` unchanged.
  - A rejected read leaves `rptr` and `rdata` unchanged.
- **Pointers:** `wptr` and `rptr` are ADDR_WIDTH+1 bits wide and wrap modulo 2*DEPTH. Memory is addressed by the low ADDR_WIDTH bits.
- **Count update:** `count` moves +1 on a write only, -1 on a read only, and holds when both or neither are accepted.
- **Flag decode:** flags are registered, decoded from next-count, so they change on the same edge as `count`:
  - `wfull` = (count == DEPTH)
  - `rempty` = (count == 0)
  - `walmost_full` = (count >= AFULL_THRESH)
  - `ralmost_empty` = (count <= AEMPTY_THRESH)
- **Simultaneous winc and rinc:**
  - Full: the read is accepted and the write rejected; count drops to DEPTH-1 and `overflow` is set.
  - Empty: the write is accepted and the read rejected; count becomes 1 and `underflow` is set.
  - Otherwise: both are accepted and count holds.
- **Error flags:**
  - `overflow` is set on `winc && wfull`.
  - `underflow` is set on `rinc && rempty`.
  - `clr_err` clears both. A set and a clear in the same cycle resolve to set.
- **Read data, FWFT=0:** `rdata` is a register loaded with `mem[rptr]` on the edge that accepts a read. It holds its value otherwise.
- **Read data, FWFT=1:** `rdata` = `mem[rptr]`, driven combinationally from the head entry. It is valid whenever `rempty`=0, and `rinc` acts as the pop/acknowledge.
- **Wrap:** no bubble or data loss across pointer wrap-around.

## Timing
- **Reset values (`wrst_n` low, asynchronous):**
  - `wptr` = `rptr` = 0, `count` = 0
  - `rempty` = 1, `wfull` = 0
  - `ralmost_empty` = 1, `walmost_full` = 0 (AFULL_THRESH >= 1)
  - `overflow` = `underflow` = 0
  - `rdata` = 0
  - Memory contents are not reset.
- **Reset mid-operation:** all of the above take effect immediately. Stored data is discarded and the first read after release returns the first word written after release.
- **Reset release:** synchronous to `wclk`; the first write may occur on the first edge with `wrst_n` high.
- **Write-to-flags latency:** a write at edge N gives `rempty`=0 and `count`=1 after edge N.
- **Read-after-write latency:**
  - FWFT=0: `rinc` may be asserted in cycle N+1, and data appears after edge N+1.
  - FWFT=1: data is on `rdata` after edge N with no `rinc`.
- **Read-to-data latency:** FWFT=0 is 1 cycle; FWFT=1 is 0 cycles, and the next head word is visible after the pop edge.
- **Throughput:** one write and one read per cycle sustained.

## Test plan
- **Reset values:** assert `wrst_n` low for 3 cycles -> all outputs at reset values, `count`=0, `rempty`=1, `ralmost_empty`=1.
- **Fill and overflow:** write 0x00..0x0F -> `walmost_full` rises at count 14, `wfull` at 16. A 17th write of 0xAA sets `overflow` and `count` stays 16. `clr_err` then clears `overflow`.
- **Drain and underflow (FWFT=0):** drain 16 reads -> `rdata` 0x00..0x0F in order, each one cycle after its read. `ralmost_empty` rises at count 2 and `rempty` at 0. An extra read sets `underflow` and `rdata` holds 0x0F.
- **Simultaneous access and wrap:**
  - At count 8, 40 cycles of simultaneous `winc`/`rinc` with incrementing data -> `count` stays 8, order is preserved across pointer wrap, no error flags.
  - At full: one simultaneous op -> `count`=15, `overflow`=1.
- **FWFT=1:** write 0x5A to an empty FIFO -> next cycle `rdata`=0x5A and `rempty`=0 without `rinc`. Pop with `rinc` -> `rempty`=1.
- **Reset mid-operation:** after 5 writes, pulse `wrst_n` low between edges -> `count`=0 and `rempty`=1 immediately. A subsequent write of 0x33 then a read returns 0x33.
